// File: rtl/mux_n1_skid_pkg.sv
// Shared constants, FSM state type and helpers for the N:1 skid-buffered selector.
package mux_n1_skid_pkg;

  // Default datapath word width.
  localparam int DEFAULT_WIDTH = 32;

  // State encoding is literally {main_valid, skid_valid}; 2'b01 is unreachable.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_ONE   = 2'b10,
    ST_FULL  = 2'b11
  } skid_state_t;

  // Ceiling log2 with a floor of 1, used to size select buses from N.
  function automatic int clog2(input int value);
    int r;
    r = 1;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/mux_n1_skid_if.sv
// Handshake bundle for mux_n1_skid.
// Valid/ready contract: a word moves on a side exactly in the cycles where that
// side's valid and ready are both 1 at the rising clock edge. A producer holding
// valid=1 keeps its payload stable until the transfer happens; ready never
// depends combinationally on the matching valid.
interface mux_n1_skid_if
  import mux_n1_skid_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int N     = 4,
  parameter int SEL_W = 2
);
  logic                 in_valid;
  logic                 in_ready;
  logic [SEL_W-1:0]     in_sel;
  logic [N*WIDTH-1:0]   in_data;
  logic                 out_valid;
  logic                 out_ready;
  logic [WIDTH-1:0]     out_data;
  logic                 out_sel_err;

  // Upstream/downstream environment side.
  modport master (
    output in_valid, in_sel, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_sel_err
  );

  // Selector block side.
  modport slave (
    input  in_valid, in_sel, in_data, out_ready,
    output in_ready, out_valid, out_data, out_sel_err
  );
endinterface

// File: rtl/mux_n1_skid_skid_reg_2.sv
// Two-entry skid register (main M drives the output, skid S absorbs one extra
// entry) giving full throughput while keeping in_ready a pure register output.
module skid_reg_2
  import mux_n1_skid_pkg::*;
#(
  parameter int W = DEFAULT_WIDTH + 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [W-1:0] in_payload,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [W-1:0] out_payload,
  output skid_state_t state
);

  skid_state_t  state_q, state_d;
  logic [W-1:0] m_data, s_data;
  logic         load_m_in, load_m_skid, load_s;
  logic         in_xfer, out_xfer;

  assign out_valid   = (state_q == ST_ONE) || (state_q == ST_FULL);
  assign in_ready    = (state_q != ST_FULL);
  assign out_payload = m_data;
  assign state       = state_q;
  assign in_xfer     = in_valid & in_ready;
  assign out_xfer    = out_valid & out_ready;

  // State register; reset drops every entry immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_EMPTY;
    else     state_q <= state_d;
  end

  // Next state and register load enables; flush empties and freezes the data.
  always_comb begin
    state_d     = state_q;
    load_m_in   = 1'b0;
    load_m_skid = 1'b0;
    load_s      = 1'b0;
    case (state_q)
      ST_EMPTY: begin
        if (in_xfer) begin
          load_m_in = 1'b1;
          state_d   = ST_ONE;
        end
      end
      ST_ONE: begin
        if (in_xfer && out_xfer) begin
          load_m_in = 1'b1;
        end else if (in_xfer) begin
          load_s  = 1'b1;
          state_d = ST_FULL;
        end else if (out_xfer) begin
          state_d = ST_EMPTY;
        end
      end
      ST_FULL: begin
        if (out_xfer) begin
          load_m_skid = 1'b1;
          state_d     = ST_ONE;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
    if (flush) begin
      state_d     = ST_EMPTY;
      load_m_in   = 1'b0;
      load_m_skid = 1'b0;
      load_s      = 1'b0;
    end
  end

  // Payload registers: M takes new input or the skid entry, S takes overflow.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_data <= '0;
      s_data <= '0;
    end else begin
      if (load_m_in)        m_data <= in_payload;
      else if (load_m_skid) m_data <= s_data;
      if (load_s)           s_data <= in_payload;
    end
  end

endmodule

// File: rtl/mux_n1_skid.sv
// N:1 word selector with registered, flow-controlled output. The select and
// out-of-range flag are computed combinationally and stored as one payload.
module mux_n1_skid
  import mux_n1_skid_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int N     = 4,
  parameter int SEL_W = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  mux_n1_skid_if.slave bus,
  output skid_state_t  dbg_state
);

  if (N < 2 || N > 16) begin : g_bad_n
    $error("mux_n1_skid: N must be within 2..16");
  end
  if ((1 << SEL_W) < N) begin : g_bad_sel_w
    $error("mux_n1_skid: SEL_W too narrow for N");
  end

  logic [WIDTH-1:0] sel_word;
  logic             sel_err;
  logic [WIDTH:0]   out_payload;

  // Word select; any select with no matching word yields zero and the error flag.
  always_comb begin
    sel_word = '0;
    sel_err  = 1'b1;
    for (int k = 0; k < N; k++) begin
      if (bus.in_sel == SEL_W'(k)) begin
        sel_word = bus.in_data[k*WIDTH +: WIDTH];
        sel_err  = 1'b0;
      end
    end
  end

  skid_reg_2 #(.W(WIDTH + 1)) u_skid (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .in_valid   (bus.in_valid),
    .in_ready   (bus.in_ready),
    .in_payload ({sel_err, sel_word}),
    .out_valid  (bus.out_valid),
    .out_ready  (bus.out_ready),
    .out_payload(out_payload),
    .state      (dbg_state)
  );

  assign bus.out_data    = out_payload[WIDTH-1:0];
  assign bus.out_sel_err = out_payload[WIDTH];

endmodule

// File: tb/tb_mux_n1_skid.sv
// Directed bench for mux_n1_skid: a N=4 instance for the main tests and a N=3
// instance for out-of-range selects.
module tb_mux_n1_skid;
  import mux_n1_skid_pkg::*;

  localparam int W = 32;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic flush = 1'b0;
  always #5 clk = ~clk;

  mux_n1_skid_if #(.WIDTH(W), .N(4), .SEL_W(clog2(4))) a_if ();
  mux_n1_skid_if #(.WIDTH(W), .N(3), .SEL_W(clog2(3))) b_if ();
  skid_state_t a_state, b_state;

  mux_n1_skid #(.WIDTH(W), .N(4), .SEL_W(clog2(4))) dut_a (
    .clk(clk), .rst(rst), .flush(flush), .bus(a_if.slave), .dbg_state(a_state)
  );
  mux_n1_skid #(.WIDTH(W), .N(3), .SEL_W(clog2(3))) dut_b (
    .clk(clk), .rst(rst), .flush(flush), .bus(b_if.slave), .dbg_state(b_state)
  );

  // ---------------- scoreboard ----------------
  int total = 0;
  int bad   = 0;
  logic [W-1:0] exp_q[$];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic a_drive(input logic v, input logic [1:0] s, input logic r);
    a_if.in_valid  = v;
    a_if.in_sel    = s;
    a_if.out_ready = r;
  endtask

  task automatic a_expect(input string tag, input logic v, input logic [W-1:0] d,
                          input logic e, input logic rdy);
    chk({tag, ".valid"}, 64'(a_if.out_valid), 64'(v));
    chk({tag, ".data"},  64'(a_if.out_data),  64'(d));
    chk({tag, ".err"},   64'(a_if.out_sel_err), 64'(e));
    chk({tag, ".ready"}, 64'(a_if.in_ready),  64'(rdy));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [W-1:0] exp_w;
    a_if.in_data = {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111};
    b_if.in_data = {32'h33333333, 32'h22222222, 32'h11111111};
    a_drive(1'b0, 2'd0, 1'b1);
    b_if.in_valid = 1'b0; b_if.in_sel = 2'd0; b_if.out_ready = 1'b1;

    // Reset state
    #1;
    a_expect("reset", 1'b0, '0, 1'b0, 1'b1);
    chk("reset.state", 64'(a_state), 64'(ST_EMPTY));
    chk("reset.b_valid", 64'(b_if.out_valid), 64'd0);
    #11 rst = 1'b0;
    tick();

    // 1. Pass-through, sel=2
    a_drive(1'b1, 2'd2, 1'b1);
    tick();
    a_expect("pass", 1'b1, 32'h33333333, 1'b0, 1'b1);
    a_drive(1'b0, 2'd0, 1'b1);
    tick();
    chk("pass.drain", 64'(a_if.out_valid), 64'd0);

    // 2. Streaming sel 0..3 back to back
    exp_q.push_back(32'h11111111);
    exp_q.push_back(32'h22222222);
    exp_q.push_back(32'h33333333);
    exp_q.push_back(32'h44444444);
    for (int i = 0; i < 4; i++) begin
      a_drive(1'b1, 2'(i), 1'b1);
      tick();
      exp_w = exp_q.pop_front();
      a_expect($sformatf("stream%0d", i), 1'b1, exp_w, 1'b0, 1'b1);
    end
    a_drive(1'b0, 2'd0, 1'b1);
    tick();
    chk("stream.drain", 64'(a_if.out_valid), 64'd0);

    // 3. Backpressure: sel=1 then sel=3 with out_ready low
    a_drive(1'b1, 2'd1, 1'b0);
    tick();
    a_expect("bp.one", 1'b1, 32'h22222222, 1'b0, 1'b1);
    a_drive(1'b1, 2'd3, 1'b0);
    tick();
    a_expect("bp.full", 1'b1, 32'h22222222, 1'b0, 1'b0);
    chk("bp.state", 64'(a_state), 64'(ST_FULL));
    a_drive(1'b0, 2'd0, 1'b0);
    tick();
    a_expect("bp.hold", 1'b1, 32'h22222222, 1'b0, 1'b0);
    a_drive(1'b0, 2'd0, 1'b1);
    tick();
    a_expect("bp.drain1", 1'b1, 32'h44444444, 1'b0, 1'b1);
    tick();
    chk("bp.drain2", 64'(a_if.out_valid), 64'd0);

    // 4. Out-of-range select on the N=3 instance
    b_if.in_valid = 1'b1; b_if.in_sel = 2'd3;
    tick();
    chk("badsel.valid", 64'(b_if.out_valid), 64'd1);
    chk("badsel.data",  64'(b_if.out_data), 64'd0);
    chk("badsel.err",   64'(b_if.out_sel_err), 64'd1);
    b_if.in_sel = 2'd0;
    tick();
    chk("sel0.data", 64'(b_if.out_data), 64'h11111111);
    chk("sel0.err",  64'(b_if.out_sel_err), 64'd0);
    b_if.in_sel = 2'd2;
    tick();
    chk("sel2.data", 64'(b_if.out_data), 64'h33333333);
    chk("sel2.err",  64'(b_if.out_sel_err), 64'd0);
    b_if.in_valid = 1'b0;
    tick();
    chk("b.drain", 64'(b_if.out_valid), 64'd0);

    // 5a. Flush while FULL with in_valid high
    a_drive(1'b1, 2'd0, 1'b0);
    tick();
    a_drive(1'b1, 2'd1, 1'b0);
    tick();
    chk("flush.pre_ready", 64'(a_if.in_ready), 64'd0);
    flush = 1'b1;
    a_drive(1'b1, 2'd2, 1'b0);
    tick();
    flush = 1'b0;
    chk("flush.valid", 64'(a_if.out_valid), 64'd0);
    chk("flush.ready", 64'(a_if.in_ready), 64'd1);
    chk("flush.state", 64'(a_state), 64'(ST_EMPTY));
    a_drive(1'b0, 2'd0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("flush.quiet%0d", i), 64'(a_if.out_valid), 64'd0);
    end

    // 5b. Flush overrides an input transfer in ONE
    a_drive(1'b1, 2'd3, 1'b1);
    tick();
    chk("flush2.pre", 64'(a_if.out_data), 64'h44444444);
    flush = 1'b1;
    a_drive(1'b1, 2'd0, 1'b1);
    tick();
    flush = 1'b0;
    a_drive(1'b0, 2'd0, 1'b1);
    chk("flush2.valid", 64'(a_if.out_valid), 64'd0);
    tick();
    chk("flush2.after", 64'(a_if.out_valid), 64'd0);

    // 6. Async reset between edges while FULL
    a_drive(1'b1, 2'd0, 1'b0);
    tick();
    a_drive(1'b1, 2'd1, 1'b0);
    tick();
    a_drive(1'b0, 2'd0, 1'b0);
    chk("arst.pre_state", 64'(a_state), 64'(ST_FULL));
    #2 rst = 1'b1;
    #1;
    a_expect("arst", 1'b0, '0, 1'b0, 1'b1);
    #1 rst = 1'b0;
    a_drive(1'b1, 2'd3, 1'b1);
    tick();
    a_expect("arst.resume", 1'b1, 32'h44444444, 1'b0, 1'b1);
    a_drive(1'b0, 2'd0, 1'b1);
    tick();
    chk("arst.drain", 64'(a_if.out_valid), 64'd0);

    // ---------------- report ----------------
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
